// File: rtl/cpu_mem_stage.sv
// Memory-access stage: forwards ALU results to writeback and runs one req/ack data-bus
// transaction per load/store. Optional bus timeout abort is enabled by CPU_MEM_TIMEOUT_EN.
module cpu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  register_write_index_i,
  input  logic        register_write_enable_i,
  input  logic        memory_read_enable_i,
  input  logic        memory_write_enable_i,
  input  logic [31:0] memory_address_i,
  input  logic [31:0] reg_result_i,
  input  logic [31:0] mem_result_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        wb_enable_o,
  output logic [3:0]  wb_index_o,
  output logic [31:0] wb_data_o,
  output logic        bus_error_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cpu_mem_stage: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  idx_q, idx_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  wb_idx_q, wb_idx_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        stall;

`ifdef CPU_MEM_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wb_en_d   = 1'b0;
    wb_idx_d  = wb_idx_q;
    wb_data_d = wb_data_q;
    stall     = 1'b0;
`ifdef CPU_MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (memory_write_enable_i || memory_read_enable_i) begin
          stall   = 1'b1;
          state_d = BUS;
          addr_d  = memory_address_i;
          wdata_d = mem_result_i;
          we_d    = memory_write_enable_i;
          idx_d   = register_write_index_i;
`ifdef CPU_MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
          // Push: the pointer update retires now, independent of the bus write.
          if (memory_write_enable_i && register_write_enable_i) begin
            wb_en_d   = 1'b1;
            wb_idx_d  = register_write_index_i;
            wb_data_d = reg_result_i;
          end
        end else begin
          wb_en_d   = register_write_enable_i;
          wb_idx_d  = register_write_index_i;
          wb_data_d = reg_result_i;
        end
      end
      BUS: begin
        stall = !dmem_ack_i;
        if (dmem_ack_i) begin
          state_d = IDLE;
          if (!we_q) begin
            wb_en_d   = 1'b1;
            wb_idx_d  = idx_q;
            wb_data_d = dmem_rdata_i;
          end
        end
`ifdef CPU_MEM_TIMEOUT_EN
        else if (cnt_q == TMO_LIMIT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_idx_q  <= '0;
      wb_data_q <= '0;
`ifdef CPU_MEM_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      wb_en_q   <= wb_en_d;
      wb_idx_q  <= wb_idx_d;
      wb_data_q <= wb_data_d;
`ifdef CPU_MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign stall_o      = stall;
  assign dmem_req_o   = (state_q == BUS);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_enable_o  = wb_en_q;
  assign wb_index_o   = wb_idx_q;
  assign wb_data_o    = wb_data_q;
`ifdef CPU_MEM_TIMEOUT_EN
  assign bus_error_o  = err_q;
`else
  assign bus_error_o  = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mem_stage.sv
// Directed bench for cpu_mem_stage: per-cycle vector table plus hand sequences for
// timeout (or its absence) and reset during a bus transaction.
module tb_cpu_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  register_write_index_i;
  logic        register_write_enable_i;
  logic        memory_read_enable_i;
  logic        memory_write_enable_i;
  logic [31:0] memory_address_i;
  logic [31:0] reg_result_i;
  logic [31:0] mem_result_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic        wb_enable_o;
  logic [3:0]  wb_index_o;
  logic [31:0] wb_data_o;
  logic        bus_error_o;

  int unsigned n_applied = 0;
  int unsigned n_miss    = 0;

  cpu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .register_write_index_i  (register_write_index_i),
    .register_write_enable_i (register_write_enable_i),
    .memory_read_enable_i    (memory_read_enable_i),
    .memory_write_enable_i   (memory_write_enable_i),
    .memory_address_i        (memory_address_i),
    .reg_result_i            (reg_result_i),
    .mem_result_i            (mem_result_i),
    .stall_o                 (stall_o),
    .dmem_req_o              (dmem_req_o),
    .dmem_we_o               (dmem_we_o),
    .dmem_addr_o             (dmem_addr_o),
    .dmem_wdata_o            (dmem_wdata_o),
    .dmem_rdata_i            (dmem_rdata_i),
    .dmem_ack_i              (dmem_ack_i),
    .wb_enable_o             (wb_enable_o),
    .wb_index_o              (wb_index_o),
    .wb_data_o               (wb_data_o),
    .bus_error_o             (bus_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rwe;
    logic [3:0]  ridx;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] rres;
    logic [31:0] mres;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_wbe;
    logic [3:0]  e_wbi;
    logic [31:0] e_wbd;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rwe, input logic [3:0] ridx, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] rres, input logic [31:0] mres,
                       input logic ack, input logic [31:0] rdata);
    register_write_enable_i = rwe;
    register_write_index_i  = ridx;
    memory_read_enable_i    = rd;
    memory_write_enable_i   = wr;
    memory_address_i        = addr;
    reg_result_i            = rres;
    mem_result_i            = mres;
    dmem_ack_i              = ack;
    dmem_rdata_i            = rdata;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 4'h0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //          rwe ridx rd wr addr          rres          mres          ack rdata        | stall req we addr        wdata         wbe wbi  wbd
    vecs[0]  = '{1, 4'd3, 0, 0, 32'h0,        32'h12345678, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        1, 4'd3, 32'h12345678};
    vecs[1]  = '{0, 4'd0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,    32'h0,        0, 4'd0, 32'h0};
    vecs[2]  = '{1, 4'd5, 1, 0, 32'h1000,     32'h55,       32'h77,       0, 32'h0,        1, 0, 0, 32'h0,    32'h0,        0, 4'd0, 32'h0};
    vecs[3]  = '{1, 4'd9, 0, 0, 32'h0,        32'h99,       32'h0,        0, 32'h1111,     1, 1, 0, 32'h1000, 32'h0,        0, 4'd0, 32'h0};
    vecs[4]  = '{1, 4'd9, 0, 0, 32'h0,        32'h99,       32'h0,        0, 32'h1111,     1, 1, 0, 32'h1000, 32'h0,        0, 4'd0, 32'h0};
    vecs[5]  = '{1, 4'd9, 0, 0, 32'h0,        32'h99,       32'h0,        0, 32'h1111,     1, 1, 0, 32'h1000, 32'h0,        0, 4'd0, 32'h0};
    vecs[6]  = '{1, 4'd9, 0, 0, 32'h0,        32'h99,       32'h0,        1, 32'hDEADBEEF, 0, 1, 0, 32'h1000, 32'h0,        1, 4'd5, 32'hDEADBEEF};
    vecs[7]  = '{0, 4'd0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        0, 4'd0, 32'h0};
    vecs[8]  = '{1, 4'd1, 1, 1, 32'h0FFC,     32'h0FFC,     32'hCAFE,     0, 32'h0,        1, 0, 0, 32'h0,    32'h0,        1, 4'd1, 32'h0FFC};
    vecs[9]  = '{1, 4'd7, 0, 0, 32'h0,        32'hBAD,      32'h0,        1, 32'h0,        0, 1, 1, 32'h0FFC, 32'hCAFE,     0, 4'd0, 32'h0};
    vecs[10] = '{0, 4'd2, 1, 0, 32'h2000,     32'h0,        32'h0,        0, 32'h0,        1, 0, 0, 32'h0,    32'h0,        0, 4'd0, 32'h0};
    vecs[11] = '{0, 4'd0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0BADF00D, 0, 1, 0, 32'h2000, 32'h0,        1, 4'd2, 32'h0BADF00D};
    vecs[12] = '{0, 4'd0, 0, 1, 32'h3000,     32'h0,        32'h11112222, 0, 32'h0,        1, 0, 0, 32'h0,    32'h0,        0, 4'd0, 32'h0};
    vecs[13] = '{1, 4'd8, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1, 1, 1, 32'h3000, 32'h11112222, 0, 4'd0, 32'h0};
    vecs[14] = '{1, 4'd8, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h55555555, 0, 1, 1, 32'h3000, 32'h11112222, 0, 4'd0, 32'h0};
    vecs[15] = '{1, 4'd4, 0, 0, 32'h0,        32'hAAAA,     32'h0,        1, 32'h0,        0, 0, 0, 32'h0,    32'h0,        1, 4'd4, 32'hAAAA};

    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_wbe", 32'(wb_enable_o), 32'd0);
    chk("rst_wbi", 32'(wb_index_o), 32'd0);
    chk("rst_wbd", wb_data_o, 32'd0);
    chk("rst_err", 32'(bus_error_o), 32'd0);
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rwe, vecs[i].ridx, vecs[i].rd, vecs[i].wr, vecs[i].addr,
            vecs[i].rres, vecs[i].mres, vecs[i].ack, vecs[i].rdata);
      @(negedge clk_i);
      chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_req", i), 32'(dmem_req_o), 32'(vecs[i].e_req));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_we", i), 32'(dmem_we_o), 32'(vecs[i].e_we));
        chk($sformatf("v%0d_addr", i), dmem_addr_o, vecs[i].e_addr);
        if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), dmem_wdata_o, vecs[i].e_wdata);
      end
      step();
      chk($sformatf("v%0d_wbe", i), 32'(wb_enable_o), 32'(vecs[i].e_wbe));
      chk($sformatf("v%0d_err", i), 32'(bus_error_o), 32'd0);
      if (vecs[i].e_wbe) begin
        chk($sformatf("v%0d_wbi", i), 32'(wb_index_o), 32'(vecs[i].e_wbi));
        chk($sformatf("v%0d_wbd", i), wb_data_o, vecs[i].e_wbd);
      end
    end

`ifdef CPU_MEM_TIMEOUT_EN
    // Run 0: no ack, abort after 5 BUS cycles. Run 1: ack on the expiry cycle.
    for (int r = 0; r < 2; r++) begin
      drive(1'b0, 4'd6, 1'b1, 1'b0, 32'h4000, '0, '0, 1'b0, '0);
      step();
      for (int c = 0; c < 5; c++) begin
        drive(1'b0, 4'd0, 1'b0, 1'b0, '0, '0, '0, (r == 1 && c == 4), 32'h13572468);
        @(negedge clk_i);
        chk($sformatf("tmo%0d_req_c%0d", r, c), 32'(dmem_req_o), 32'd1);
        step();
        if (c < 4) begin
          chk($sformatf("tmo%0d_wbe_c%0d", r, c), 32'(wb_enable_o), 32'd0);
          chk($sformatf("tmo%0d_err_c%0d", r, c), 32'(bus_error_o), 32'd0);
        end
      end
      idle_inputs();
      chk($sformatf("tmo%0d_req_end", r), 32'(dmem_req_o), 32'd0);
      chk($sformatf("tmo%0d_err_end", r), 32'(bus_error_o), (r == 0) ? 32'd1 : 32'd0);
      chk($sformatf("tmo%0d_wbe_end", r), 32'(wb_enable_o), (r == 0) ? 32'd0 : 32'd1);
      if (r == 1) chk("tmo1_wbd", wb_data_o, 32'h13572468);
      step();
      chk($sformatf("tmo%0d_err_after", r), 32'(bus_error_o), 32'd0);
    end
`else
    drive(1'b0, 4'd6, 1'b1, 1'b0, 32'h4000, '0, '0, 1'b0, '0);
    step();
    idle_inputs();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      chk($sformatf("wait_req_c%0d", c), 32'(dmem_req_o), 32'd1);
      chk($sformatf("wait_stall_c%0d", c), 32'(stall_o), 32'd1);
      step();
      chk($sformatf("wait_err_c%0d", c), 32'(bus_error_o), 32'd0);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h13572468);
    step();
    idle_inputs();
    chk("wait_wbe", 32'(wb_enable_o), 32'd1);
    chk("wait_wbi", 32'(wb_index_o), 32'd6);
    chk("wait_wbd", wb_data_o, 32'h13572468);
`endif

    // Reset in the second wait cycle of a load.
    drive(1'b0, 4'd3, 1'b1, 1'b0, 32'h5000, '0, '0, 1'b0, '0);
    step();
    idle_inputs();
    step();
    #3;
    chk("mid_req_before", 32'(dmem_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_req_rst", 32'(dmem_req_o), 32'd0);
    chk("mid_stall_rst", 32'(stall_o), 32'd0);
    step();
    rst_i = 1'b0;
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hFFFF0000;
    step();
    chk("mid_wbe", 32'(wb_enable_o), 32'd0);
    chk("mid_err", 32'(bus_error_o), 32'd0);
    chk("mid_req_after", 32'(dmem_req_o), 32'd0);
    drive(1'b1, 4'hA, 1'b0, 1'b0, '0, 32'h600DF00D, '0, 1'b0, '0);
    @(negedge clk_i);
    chk("post_stall", 32'(stall_o), 32'd0);
    step();
    idle_inputs();
    chk("post_wbe", 32'(wb_enable_o), 32'd1);
    chk("post_wbi", 32'(wb_index_o), 32'hA);
    chk("post_wbd", wb_data_o, 32'h600DF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
